mem_resp_ctrl: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/mem_resp_if.sv | 32 +++
 rtl/mem_resp_array.sv | 38 +++
 rtl/mem_resp_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_resp_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM states,
// wait-state counter width and byte-lane helpers.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W      = 4;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = DATA_W_DEF / 8;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// Request/response channel between the core's memory port (master) and
// the word-storage responder (slave).
interface mem_resp_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  import mem_resp_pkg::*;

  localparam int LANES = be_width(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LANES-1:0]  req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_resp_array.sv
// DEPTH x DATA_W word store, one synchronous port with per-byte write
// enables and a registered, enable-gated read. Contents are never reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic                        re_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic [be_width(DATA_W)-1:0] be_i,
  input  logic [DATA_W-1:0]           wdata_i,
  output logic [DATA_W-1:0]           rdata_o
);

  localparam int LANES = be_width(DATA_W);

  // One 8-bit wide array per lane so each maps onto its own RAM column.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (we_i && be_i[gi]) begin
        lane_mem[addr_i] <= wdata_i[8*gi +: 8];
      end
      if (re_i) begin
        lane_rd_q <= lane_mem[addr_i];
      end
    end

    assign rdata_o[8*gi +: 8] = lane_rd_q;
  end

endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory-side responder: accepts one word request at a time, waits
// WAIT_CYCLES, commits to the array on entry to RESP and holds the response.
module mem_resp_ctrl
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  mem_resp_if.slave  bus
);

  localparam int               LANES    = be_width(DATA_W);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_en_q;
  logic              err_q;
  logic              rd_ok_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  be_q;

  logic              accept;
  logic              commit;
  logic              req_ready;
  logic              resp_valid;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [LANES-1:0]  c_be;
  logic              in_range;
  logic [DATA_W-1:0] arr_rdata;

  // With zero wait states the commit edge is the accept edge, so the
  // request fields come straight from the bus instead of the holding regs.
  assign c_we     = (state_q == IDLE) ? bus.req_we    : we_q;
  assign c_addr   = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign c_wdata  = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign c_be     = (state_q == IDLE) ? bus.req_be    : be_q;
  assign in_range = ({1'b0, c_addr} < DEPTH_L);
  assign commit   = (state_d == RESP) && (state_q != RESP) && !rst;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = rdy_en_q;
        if (bus.req_valid && rdy_en_q) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
      if (commit) begin
        err_q   <= !in_range;
        rd_ok_q <= !c_we && in_range;
      end
    end
  end

  mem_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (commit && c_we && in_range),
    .re_i    (commit && !c_we && in_range),
    .addr_i  (c_addr),
    .be_i    (c_be),
    .wdata_i (c_wdata),
    .rdata_o (arr_rdata)
  );

  // The array read register only moves on a read commit, so the response
  // stays stable under backpressure; writes and errors present zero data.
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = ((state_q == RESP) && rd_ok_q) ? arr_rdata : '0;
  assign bus.resp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed bench for mem_resp_ctrl: three instances (W=1/DEPTH=48, W=3,
// W=0) share one driver; a scoreboard queue holds the expected responses.
module tb_mem_resp_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  int          tests = 0;
  int          fails = 0;

  logic        t_valid, t_we, t_resp_ready;
  logic [5:0]  t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_be;

  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0] o_resp_rdata;

  exp_t        sb[$];
  logic [31:0] model [3][64];
  int          wait_of  [3] = '{1, 3, 0};
  int          depth_of [3] = '{48, 64, 64};

  always #5 clk = ~clk;

  mem_resp_if #(.ADDR_W(6), .DATA_W(32)) if_a ();
  mem_resp_if #(.ADDR_W(6), .DATA_W(32)) if_b ();
  mem_resp_if #(.ADDR_W(6), .DATA_W(32)) if_c ();

  assign if_a.req_valid = t_valid && (sel == 0);
  assign if_b.req_valid = t_valid && (sel == 1);
  assign if_c.req_valid = t_valid && (sel == 2);
  assign {if_a.req_we, if_b.req_we, if_c.req_we}             = {3{t_we}};
  assign {if_a.req_addr, if_b.req_addr, if_c.req_addr}       = {3{t_addr}};
  assign {if_a.req_wdata, if_b.req_wdata, if_c.req_wdata}    = {3{t_wdata}};
  assign {if_a.req_be, if_b.req_be, if_c.req_be}             = {3{t_be}};
  assign {if_a.resp_ready, if_b.resp_ready, if_c.resp_ready} = {3{t_resp_ready}};

  mem_resp_ctrl #(.ADDR_W(6), .DATA_W(32), .DEPTH(48), .WAIT_CYCLES(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mem_resp_ctrl #(.ADDR_W(6), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(3))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  mem_resp_ctrl #(.ADDR_W(6), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  always_comb begin
    o_req_ready  = if_a.req_ready;
    o_resp_valid = if_a.resp_valid;
    o_resp_rdata = if_a.resp_rdata;
    o_resp_err   = if_a.resp_err;
    case (sel)
      1: begin
        o_req_ready  = if_b.req_ready;
        o_resp_valid = if_b.resp_valid;
        o_resp_rdata = if_b.resp_rdata;
        o_resp_err   = if_b.resp_err;
      end
      2: begin
        o_req_ready  = if_c.req_ready;
        o_resp_valid = if_c.resp_valid;
        o_resp_rdata = if_c.resp_rdata;
        o_resp_err   = if_c.resp_err;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int s);
    sel = s;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one committed request; updates the model array.
  function automatic exp_t model_txn(input logic we, input logic [5:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    logic [31:0] w;
    e = '{rdata: 32'h0, err: 1'b0};
    if (int'(addr) >= depth_of[sel]) begin
      e.err = 1'b1;
    end else if (we) begin
      w = model[sel][addr];
      for (int l = 0; l < 4; l++) begin
        if (be[l]) w[8*l +: 8] = wdata[8*l +: 8];
      end
      model[sel][addr] = w;
    end else begin
      e.rdata = model[sel][addr];
    end
    return e;
  endfunction

  // Present a request, wait (bounded) for acceptance, push its expectation.
  task automatic issue(input string tag, input logic we, input logic [5:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    t_we = we; t_addr = addr; t_wdata = wdata; t_be = be; t_valid = 1'b1;
    for (int i = 0; i < 20 && !o_req_ready; i++) tick();
    checkb({tag, " accept"}, o_req_ready, 1'b1);
    if (o_req_ready) sb.push_back(model_txn(we, addr, wdata, be));
    tick();
    t_valid = 1'b0;
  endtask

  // Called one cycle after the accept edge; returns the expected response.
  task automatic wait_resp(input string tag, input int exp_lat, output exp_t e);
    int lat = 1;
    e = '{rdata: 32'h0, err: 1'b0};
    while (!o_resp_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    if (o_resp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " rdata"}, o_resp_rdata, e.rdata);
      checkb({tag, " err"}, o_resp_err, e.err);
    end else begin
      checkb({tag, " resp_valid"}, o_resp_valid, 1'b1);
    end
    $display("[TB] dut%0d %s lat=%0d rdata=%h err=%b", sel, tag, lat, o_resp_rdata, o_resp_err);
    if (t_resp_ready) tick();
  endtask

  task automatic txn(input string tag, input logic we, input logic [5:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    issue(tag, we, addr, wdata, be);
    wait_resp(tag, wait_of[sel] + 1, e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t held;
    int   cyc, done, issued, acc_cyc, last_resp;
    logic acc_now;

    rst = 1'b1; sel = 0; t_valid = 1'b0; t_we = 1'b0; t_addr = '0;
    t_wdata = '0; t_be = '0; t_resp_ready = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      checkb("reset req_ready", o_req_ready, 1'b0);
      checkb("reset resp_valid", o_resp_valid, 1'b0);
      check("reset rdata", o_resp_rdata, 32'h0);
      checkb("reset err", o_resp_err, 1'b0);
    end
    rst = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      checkb("post-reset req_ready", o_req_ready, 1'b1);
    end

    // Instance A: WAIT_CYCLES=1, DEPTH=48
    set_sel(0);
    txn("wr5 full", 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    txn("rd5", 1'b0, 6'd5, 32'h0, 4'h0);
    txn("wr5 be0101", 1'b1, 6'd5, 32'h11223344, 4'b0101);
    txn("rd5 merged", 1'b0, 6'd5, 32'h0, 4'h0);
    check("merge model", model[0][5], 32'hDE22BE44);
    txn("wr50 oor", 1'b1, 6'd50, 32'h55555555, 4'hF);
    txn("rd50 oor", 1'b0, 6'd50, 32'h0, 4'h0);
    txn("wr47", 1'b1, 6'd47, 32'hA5A5_0F0F, 4'hF);
    txn("rd47", 1'b0, 6'd47, 32'h0, 4'h0);

    // Backpressure: response held for 10 cycles with a request pending.
    t_resp_ready = 1'b0;
    issue("bp rd5", 1'b0, 6'd5, 32'h0, 4'h0);
    wait_resp("bp rd5", 2, held);
    t_we = 1'b0; t_addr = 6'd47; t_wdata = '0; t_be = '0; t_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkb("bp resp_valid", o_resp_valid, 1'b1);
      check("bp rdata", o_resp_rdata, held.rdata);
      checkb("bp err", o_resp_err, held.err);
      checkb("bp req_ready", o_req_ready, 1'b0);
    end
    t_resp_ready = 1'b1;
    tick();
    checkb("bp pending accepted", o_req_ready, 1'b1);
    issue("bp pending rd47", 1'b0, 6'd47, 32'h0, 4'h0);
    wait_resp("bp pending rd47", 2, held);

    txn("wr47 be0", 1'b1, 6'd47, 32'hFFFFFFFF, 4'h0);
    txn("rd47 unchanged", 1'b0, 6'd47, 32'h0, 4'h0);

    // Instance B: WAIT_CYCLES=3, reset during WAIT drops the write.
    set_sel(1);
    txn("wr9 init", 1'b1, 6'd9, 32'h12345678, 4'hF);
    t_we = 1'b1; t_addr = 6'd9; t_wdata = 32'hCAFEF00D; t_be = 4'hF; t_valid = 1'b1;
    checkb("midwait accept", o_req_ready, 1'b1);
    tick();
    t_valid = 1'b0;
    rst = 1'b1;
    tick();
    checkb("midwait rst req_ready", o_req_ready, 1'b0);
    checkb("midwait rst resp_valid", o_resp_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkb("midwait dropped resp_valid", o_resp_valid, 1'b0);
    end
    checkb("midwait req_ready", o_req_ready, 1'b1);
    txn("rd9 after drop", 1'b0, 6'd9, 32'h0, 4'h0);

    // Instance C: WAIT_CYCLES=0, back-to-back reads with resp_ready high.
    set_sel(2);
    for (int i = 0; i < 8; i++) begin
      txn("c wr", 1'b1, 6'(i + 16), 32'h1000_0000 * (i + 1) + 32'(i), 4'hF);
    end
    cyc = 0; done = 0; issued = 0; acc_cyc = 0; last_resp = 0;
    t_we = 1'b0; t_addr = 6'd16; t_valid = 1'b1;
    while (done < 8 && cyc < 100) begin
      if (o_resp_valid) begin
        if (sb.size() > 0) begin
          held = sb.pop_front();
          check("stream rdata", o_resp_rdata, held.rdata);
          checkb("stream err", o_resp_err, held.err);
        end else begin
          checkb("stream unexpected resp", o_resp_valid, 1'b0);
        end
        check("stream latency", cyc - acc_cyc, 32'd1);
        if (done > 0) check("stream interval", cyc - last_resp, 32'd2);
        $display("[TB] dut2 stream read #%0d cyc=%0d rdata=%h", done, cyc, o_resp_rdata);
        last_resp = cyc;
        done++;
      end
      acc_now = o_req_ready && t_valid;
      if (acc_now) begin
        sb.push_back(model_txn(1'b0, t_addr, 32'h0, 4'h0));
        acc_cyc = cyc;
        issued++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (issued < 8) t_addr = t_addr + 6'd1;
        else t_valid = 1'b0;
      end
    end
    t_valid = 1'b0;
    check("stream completions", done, 32'd8);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
